// File: rtl/uart_rx_frame_ctrl.sv
// Frame capture FIFO, shadowed UART_RX configuration and error statistics
// for a UART receiver. All state is on the rising edge of RX_CLK, async-low RST.

module uart_rx_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && ~&cnt)      cnt <= cnt + 1'b1;
  end
endmodule

module uart_rx_frame_ctrl #(
  parameter int       DATA_WIDTH     = 8,
  parameter int       PRESCALE_WIDTH = 5,
  parameter int       DEPTH          = 4,
  parameter int       RST_PRESCALE   = 8,
  parameter logic     RST_PAR_EN     = 1'b1,
  parameter logic     RST_PAR_TYPE   = 1'b0
) (
  input  logic                        RX_CLK,
  input  logic                        RST,
  input  logic                        RX_IN_S,
  input  logic [DATA_WIDTH-1:0]       rx_data,
  input  logic                        rx_valid,
  input  logic                        rx_par_err,
  input  logic                        rx_frm_err,
  output logic [PRESCALE_WIDTH-1:0]   Prescale,
  output logic                        parity_enable,
  output logic                        parity_type,
  input  logic                        cfg_wr,
  input  logic [PRESCALE_WIDTH-1:0]   cfg_prescale,
  input  logic                        cfg_par_en,
  input  logic                        cfg_par_type,
  output logic                        cfg_pending,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_par_err,
  output logic                        out_frm_err,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic                        overflow,
  output logic [7:0]                  par_err_cnt,
  output logic [7:0]                  frm_err_cnt,
  input  logic                        cnt_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = PRESCALE_WIDTH + 4;

  typedef struct packed {
    logic                  frm;
    logic                  par;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic {APPLIED, PENDING} cfg_state_e;

  // ---------------- capture FIFO ----------------
  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            rx_valid_q;
  logic            push, pop, full, wr_en, drop;
  entry_t          head;

  assign push  = rx_valid & ~rx_valid_q;
  assign full  = (count == CW'(DEPTH));
  assign pop   = out_valid & out_ready;
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      rx_valid_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      rx_valid_q <= rx_valid;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge RX_CLK) begin
    if (wr_en) mem[wr_ptr] <= '{frm: rx_frm_err, par: rx_par_err, data: rx_data};
  end

  // Head is forced to zero when empty so stale storage never leaks out.
  assign out_valid   = (count != '0);
  assign head        = out_valid ? mem[rd_ptr] : '0;
  assign out_data    = head.data;
  assign out_par_err = head.par;
  assign out_frm_err = head.frm;
  assign fifo_count  = count;

  // ---------------- statistics ----------------
  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST)         overflow <= 1'b0;
    else if (cnt_clr) overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
  end

  uart_rx_sat_cnt #(.W(8)) u_par_cnt (
    .clk(RX_CLK), .rst_n(RST), .clr(cnt_clr),
    .inc(push & rx_par_err), .cnt(par_err_cnt)
  );

  uart_rx_sat_cnt #(.W(8)) u_frm_cnt (
    .clk(RX_CLK), .rst_n(RST), .clr(cnt_clr),
    .inc(push & rx_frm_err), .cnt(frm_err_cnt)
  );

  // ---------------- configuration shadow ----------------
  cfg_state_e                 state, state_nx;
  logic                       apply;
  logic [IW-1:0]              idle_cnt, thresh;
  logic [PRESCALE_WIDTH-1:0]  sh_prescale;
  logic                       sh_par_en, sh_par_type;

  // Idle threshold is one 11-bit frame time at the prescale currently in use.
  assign thresh = IW'(Prescale) * IW'(11);

  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) state <= APPLIED;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    apply    = 1'b0;
    case (state)
      APPLIED: if (cfg_wr) state_nx = PENDING;
      PENDING: if (idle_cnt >= thresh) begin
        apply    = 1'b1;
        state_nx = cfg_wr ? PENDING : APPLIED;
      end
      default: state_nx = APPLIED;
    endcase
  end

  assign cfg_pending = (state == PENDING);

  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      idle_cnt      <= '0;
      sh_prescale   <= PRESCALE_WIDTH'(RST_PRESCALE);
      sh_par_en     <= RST_PAR_EN;
      sh_par_type   <= RST_PAR_TYPE;
      Prescale      <= PRESCALE_WIDTH'(RST_PRESCALE);
      parity_enable <= RST_PAR_EN;
      parity_type   <= RST_PAR_TYPE;
    end else begin
      if (apply)                        idle_cnt <= '0;
      else if (!RX_IN_S)                idle_cnt <= '0;
      else if (idle_cnt < thresh)       idle_cnt <= idle_cnt + 1'b1;

      if (apply) begin
        Prescale      <= sh_prescale;
        parity_enable <= sh_par_en;
        parity_type   <= sh_par_type;
      end
      if (cfg_wr) begin
        sh_prescale <= cfg_prescale;
        sh_par_en   <= cfg_par_en;
        sh_par_type <= cfg_par_type;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a queue-based reference model
// compared against every output one time unit after each rising edge.

module tb_uart_rx_frame_ctrl;
  localparam int DEPTH = 4;

  logic       RX_CLK = 1'b0, RST = 1'b0, RX_IN_S = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0, rx_par_err = 1'b0, rx_frm_err = 1'b0;
  logic       cfg_wr = 1'b0, cfg_par_en = 1'b0, cfg_par_type = 1'b0;
  logic [4:0] cfg_prescale = '0;
  logic       out_ready = 1'b0, cnt_clr = 1'b0;

  logic [4:0] Prescale;
  logic       parity_enable, parity_type, cfg_pending;
  logic [7:0] out_data, par_err_cnt, frm_err_cnt;
  logic       out_par_err, out_frm_err, out_valid, overflow;
  logic [2:0] fifo_count;

  uart_rx_frame_ctrl #(
    .DATA_WIDTH(8), .PRESCALE_WIDTH(5), .DEPTH(DEPTH),
    .RST_PRESCALE(8), .RST_PAR_EN(1'b1), .RST_PAR_TYPE(1'b0)
  ) dut (
    .RX_CLK(RX_CLK), .RST(RST), .RX_IN_S(RX_IN_S),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_par_err(rx_par_err), .rx_frm_err(rx_frm_err),
    .Prescale(Prescale), .parity_enable(parity_enable), .parity_type(parity_type),
    .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
    .cfg_par_type(cfg_par_type), .cfg_pending(cfg_pending),
    .out_data(out_data), .out_par_err(out_par_err), .out_frm_err(out_frm_err),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
    .overflow(overflow), .par_err_cnt(par_err_cnt), .frm_err_cnt(frm_err_cnt),
    .cnt_clr(cnt_clr)
  );

  always #5 RX_CLK = ~RX_CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [9:0] mq[$];
  bit m_prev, m_ovf, m_pend;
  int m_par, m_frm, m_idle;
  int m_pre, m_en, m_type, s_pre, s_en, s_type;

  function automatic void m_reset();
    mq.delete();
    m_prev = 0; m_ovf = 0; m_pend = 0;
    m_par = 0; m_frm = 0; m_idle = 0;
    m_pre = 8; m_en = 1; m_type = 0;
    s_pre = 8; s_en = 1; s_type = 0;
  endfunction

  always @(negedge RST) m_reset();

  always @(posedge RX_CLK) begin
    bit push, pop, apply;
    int t;
    if (!RST) m_reset();
    else begin
      push = rx_valid && !m_prev;
      m_prev = rx_valid;
      pop = (mq.size() > 0) && out_ready;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back({rx_frm_err, rx_par_err, rx_data});
        else if (!cnt_clr) m_ovf = 1;
      end
      if (cnt_clr) begin
        m_ovf = 0; m_par = 0; m_frm = 0;
      end else if (push) begin
        if (rx_par_err && m_par < 255) m_par++;
        if (rx_frm_err && m_frm < 255) m_frm++;
      end
      t = 11 * m_pre;
      apply = m_pend && (m_idle >= t);
      if (apply) begin
        m_pre = s_pre; m_en = s_en; m_type = s_type; m_idle = 0;
      end else if (!RX_IN_S) m_idle = 0;
      else if (m_idle < t) m_idle++;
      if (cfg_wr) begin
        s_pre = cfg_prescale; s_en = cfg_par_en; s_type = cfg_par_type; m_pend = 1;
      end else if (apply) m_pend = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge RX_CLK) begin
    logic [9:0] h;
    #1;
    h = (mq.size() > 0) ? mq[0] : 10'h0;
    check("out_valid",   out_valid,     mq.size() > 0);
    check("out_data",    out_data,      h[7:0]);
    check("out_par_err", out_par_err,   h[8]);
    check("out_frm_err", out_frm_err,   h[9]);
    check("fifo_count",  fifo_count,    mq.size());
    check("overflow",    overflow,      m_ovf);
    check("par_err_cnt", par_err_cnt,   m_par);
    check("frm_err_cnt", frm_err_cnt,   m_frm);
    check("Prescale",    Prescale,      m_pre);
    check("parity_en",   parity_enable, m_en);
    check("parity_type", parity_type,   m_type);
    check("cfg_pending", cfg_pending,   m_pend);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge RX_CLK);
    #3;
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic f);
    rx_data = d; rx_par_err = p; rx_frm_err = f; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  logic [7:0] s1_d [3] = '{8'hA5, 8'h3C, 8'hFF};
  logic       s1_p [3] = '{1'b0, 1'b1, 1'b0};
  logic       s1_f [3] = '{1'b0, 1'b0, 1'b1};
  logic [7:0] drain [4] = '{8'h02, 8'h03, 8'h04, 8'h66};

  initial begin
    m_reset();
    tick(); tick();
    check("rst_valid",    out_valid, 0);
    check("rst_prescale", Prescale, 8);
    check("rst_par_en",   parity_enable, 1);
    check("rst_pending",  cfg_pending, 0);
    RST = 1'b1;
    tick();

    // three frames drained as they arrive
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = s1_d[i]; rx_par_err = s1_p[i]; rx_frm_err = s1_f[i]; rx_valid = 1'b1;
      tick();
      check("s1_head", out_data, s1_d[i]);
      check("s1_valid", out_valid, 1);
      rx_valid = 1'b0;
      tick();
      check("s1_popped", out_valid, 0);
    end
    check("s1_par_cnt", par_err_cnt, 1);
    check("s1_frm_cnt", frm_err_cnt, 1);

    // held rx_valid captures once
    out_ready = 1'b0; rx_par_err = 1'b0; rx_frm_err = 1'b0;
    rx_data = 8'h11; rx_valid = 1'b1;
    repeat (3) tick();
    check("hold_count", fifo_count, 1);
    rx_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("hold_drain", fifo_count, 0);

    // overflow: five frames into four entries
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 1'b0);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag",  overflow, 1);
    check("ovf_head",  out_data, 8'h01);

    // push and pop together while full
    rx_data = 8'h66; rx_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("full_pp_count", fifo_count, 4);
    check("full_pp_head",  out_data, 8'h02);
    rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", out_data, drain[i]);
      tick();
    end
    check("drain_empty", fifo_count, 0);
    out_ready = 1'b0;

    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_par", par_err_cnt, 0);

    // shadowed config held off by line activity
    RX_IN_S = 1'b0; cfg_wr = 1'b1; cfg_prescale = 5'd16; cfg_par_en = 1'b0; cfg_par_type = 1'b1;
    tick();
    cfg_wr = 1'b0;
    check("cfg_pend", cfg_pending, 1);
    for (int k = 0; k < 3; k++) begin
      RX_IN_S = 1'b1; repeat (49) tick();
      RX_IN_S = 1'b0; tick();
    end
    check("cfg_held_pend", cfg_pending, 1);
    check("cfg_held_pre",  Prescale, 8);
    RX_IN_S = 1'b1;
    repeat (88) tick();
    check("cfg_88_pre", Prescale, 8);
    tick();
    check("cfg_apply_pre",  Prescale, 16);
    check("cfg_apply_pend", cfg_pending, 0);
    check("cfg_apply_en",   parity_enable, 0);
    check("cfg_apply_type", parity_type, 1);

    // prescale 0 gives a zero threshold
    cfg_wr = 1'b1; cfg_prescale = 5'd0; cfg_par_en = 1'b1; cfg_par_type = 1'b0;
    tick(); cfg_wr = 1'b0;
    repeat (180) tick();
    check("p0_pre", Prescale, 0);
    cfg_wr = 1'b1; cfg_prescale = 5'd9;
    tick();
    check("p0_pend", cfg_pending, 1);
    check("p0_still", Prescale, 0);
    cfg_prescale = 5'd12;
    tick();
    cfg_wr = 1'b0;
    check("apply_wr_pre",  Prescale, 9);
    check("apply_wr_pend", cfg_pending, 1);
    repeat (120) tick();
    check("p12_pre",  Prescale, 12);
    check("p12_pend", cfg_pending, 0);

    // counter saturation
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) send(8'(i), 1'b1, 1'b0);
    check("sat_par", par_err_cnt, 255);
    check("sat_frm", frm_err_cnt, 0);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("sat_clr", par_err_cnt, 0);
    check("sat_ovf", overflow, 0);

    // asynchronous reset with two entries queued and a capture in flight
    out_ready = 1'b0; rx_par_err = 1'b0;
    send(8'hC1, 1'b0, 1'b1);
    send(8'hC2, 1'b0, 1'b0);
    check("pre_rst_count", fifo_count, 2);
    rx_data = 8'h77; rx_valid = 1'b1;
    #2 RST = 1'b0;
    #1;
    check("arst_count", fifo_count, 0);
    check("arst_valid", out_valid, 0);
    check("arst_data",  out_data, 0);
    check("arst_frm",   frm_err_cnt, 0);
    check("arst_pre",   Prescale, 8);
    check("arst_pend",  cfg_pending, 0);
    tick();
    rx_valid = 1'b0; RST = 1'b1;
    tick(); tick();
    check("post_rst_count", fifo_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
